// File: rtl/call_setup.sv
// Call setup front end: debounces the hook switch, collects keypad digits,
// classifies the call and supervises the answer phase for the billing counter.
module call_setup #(
    parameter int DEBOUNCE     = 3,
    parameter int LOCAL_DIGITS = 7,
    parameter int LONG_DIGITS  = 11,
    parameter int DIGIT_TMO    = 10,
    parameter int RING_TMO     = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hook_off,
    input  logic       card,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       answer,
    input  logic       cut,
    output logic       state,
    output logic [1:0] decide,
    output logic [3:0] dial_cnt,
    output logic       busy_tone,
    output logic       digit_err
);
    localparam int DW      = $clog2(DEBOUNCE + 1);
    localparam int TMO_MAX = (RING_TMO > DIGIT_TMO) ? RING_TMO : DIGIT_TMO;
    localparam int TW      = $clog2(TMO_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DIAL, S_WAIT_ANS, S_TALK, S_FAIL
    } fsm_e;

    typedef enum logic [1:0] {
        CLS_NONE  = 2'b00,
        CLS_LOCAL = 2'b01,
        CLS_LONG  = 2'b10
    } cls_e;

    fsm_e          fsm_q, fsm_d;
    cls_e          cls_q, cls_d;
    logic          hk_q, hk_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [3:0]    dial_cnt_q, dial_cnt_d;
    logic          state_q, state_d;
    logic [1:0]    decide_q, decide_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          key_ok;
    logic [3:0]    target;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        hk_d       = hk_q;
        db_cnt_d   = '0;
        fsm_d      = fsm_q;
        cls_d      = cls_q;
        tmr_d      = tmr_q;
        dial_cnt_d = dial_cnt_q;
        err_d      = 1'b0;
        target     = 4'(LOCAL_DIGITS);
        key_ok     = key_valid && (key_code <= 4'd9);

        // The hook level only moves after DEBOUNCE consecutive differing samples.
        if (hook_off != hk_q) begin
            if (db_cnt_q == DW'(DEBOUNCE - 1)) hk_d = hook_off;
            else                               db_cnt_d = db_cnt_q + 1'b1;
        end

        if (!hk_q || !card) begin
            fsm_d = S_IDLE;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    fsm_d      = S_DIAL;
                    tmr_d      = '0;
                    dial_cnt_d = '0;
                    cls_d      = CLS_NONE;
                end
                S_DIAL: begin
                    err_d = key_valid && !key_ok;
                    if (key_ok) begin
                        tmr_d      = '0;
                        dial_cnt_d = (dial_cnt_q == 4'hF) ? dial_cnt_q : dial_cnt_q + 1'b1;
                        if (dial_cnt_q == 4'd0)
                            cls_d = (key_code == 4'd0) ? CLS_LONG : CLS_LOCAL;
                        target = (cls_d == CLS_LONG) ? 4'(LONG_DIGITS) : 4'(LOCAL_DIGITS);
                        if (dial_cnt_d == target) fsm_d = S_WAIT_ANS;
                    end else if (tmr_q == TW'(DIGIT_TMO - 1)) begin
                        fsm_d = S_FAIL;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                S_WAIT_ANS: begin
                    if (answer)                              fsm_d = S_TALK;
                    else if (tmr_q == TW'(RING_TMO - 1))     fsm_d = S_FAIL;
                    else                                     tmr_d = tmr_q + 1'b1;
                end
                S_TALK:  if (cut) fsm_d = S_FAIL;
                S_FAIL:  fsm_d = S_FAIL;
                default: fsm_d = S_IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they line up with the FSM register.
        state_d  = (fsm_d == S_TALK);
        busy_d   = (fsm_d == S_FAIL);
        decide_d = (fsm_d == S_WAIT_ANS || fsm_d == S_TALK) ? cls_d : CLS_NONE;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q      <= S_IDLE;
            cls_q      <= CLS_NONE;
            hk_q       <= 1'b0;
            db_cnt_q   <= '0;
            tmr_q      <= '0;
            dial_cnt_q <= '0;
            state_q    <= 1'b0;
            decide_q   <= 2'b00;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            cls_q      <= cls_d;
            hk_q       <= hk_d;
            db_cnt_q   <= db_cnt_d;
            tmr_q      <= tmr_d;
            dial_cnt_q <= dial_cnt_d;
            state_q    <= state_d;
            decide_q   <= decide_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign state     = state_q;
    assign decide    = decide_q;
    assign dial_cnt  = dial_cnt_q;
    assign busy_tone = busy_q;
    assign digit_err = err_q;
endmodule

// File: tb/tb_call_setup.sv
// Self-checking bench for call_setup: directed call scenarios plus a random
// run, all compared against a behavioural model of the call rules.
module tb_call_setup;
    localparam int DEBOUNCE     = 3;
    localparam int LOCAL_DIGITS = 7;
    localparam int LONG_DIGITS  = 11;
    localparam int DIGIT_TMO    = 10;
    localparam int RING_TMO     = 30;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hook_off = 1'b0;
    logic       card = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       answer = 1'b0;
    logic       cut = 1'b0;
    logic       state;
    logic [1:0] decide;
    logic [3:0] dial_cnt;
    logic       busy_tone;
    logic       digit_err;

    int n_checks = 0;
    int n_errors = 0;

    call_setup #(
        .DEBOUNCE(DEBOUNCE), .LOCAL_DIGITS(LOCAL_DIGITS), .LONG_DIGITS(LONG_DIGITS),
        .DIGIT_TMO(DIGIT_TMO), .RING_TMO(RING_TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hook_off(hook_off), .card(card),
        .key_valid(key_valid), .key_code(key_code), .answer(answer), .cut(cut),
        .state(state), .decide(decide), .dial_cnt(dial_cnt),
        .busy_tone(busy_tone), .digit_err(digit_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: call phase, list of dialled digits, cycles waited.
    typedef enum {P_IDLE, P_DIAL, P_WAIT, P_TALK, P_FAIL} phase_e;
    phase_e m_phase;
    int     m_digits[$];
    int     m_waited;
    int     m_hk;
    int     m_run;
    bit     m_err;

    function automatic void model_reset();
        m_phase = P_IDLE;
        m_digits.delete();
        m_waited = 0;
        m_hk = 0;
        m_run = 0;
        m_err = 0;
    endfunction

    function automatic int goal();
        return (m_digits[0] == 0) ? LONG_DIGITS : LOCAL_DIGITS;
    endfunction

    function automatic void model_step();
        m_err = 0;
        if (m_hk == 0 || !card) begin
            m_phase = P_IDLE;
        end else if (m_phase == P_IDLE) begin
            m_phase = P_DIAL;
            m_digits.delete();
            m_waited = 0;
        end else if (m_phase == P_DIAL) begin
            if (key_valid && key_code <= 9) begin
                m_digits.push_back(int'(key_code));
                m_waited = 0;
                if (m_digits.size() == goal()) m_phase = P_WAIT;
            end else begin
                if (key_valid) m_err = 1;
                m_waited++;
                if (m_waited >= DIGIT_TMO) m_phase = P_FAIL;
            end
        end else if (m_phase == P_WAIT) begin
            if (answer) m_phase = P_TALK;
            else begin
                m_waited++;
                if (m_waited >= RING_TMO) m_phase = P_FAIL;
            end
        end else if (m_phase == P_TALK) begin
            if (cut) m_phase = P_FAIL;
        end
        if (int'(hook_off) != m_hk) begin
            m_run++;
            if (m_run >= DEBOUNCE) begin
                m_hk = int'(hook_off);
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
    endfunction

    function automatic logic [8:0] model_outs();
        logic [1:0] d;
        logic [3:0] n;
        d = 2'b00;
        if (m_phase == P_WAIT || m_phase == P_TALK) d = (m_digits[0] == 0) ? 2'b10 : 2'b01;
        n = (m_digits.size() > 15) ? 4'd15 : 4'(m_digits.size());
        return {m_phase == P_TALK, d, n, m_phase == P_FAIL, m_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        check("cycle", {23'd0, state, decide, dial_cnt, busy_tone, digit_err}, {23'd0, model_outs()});
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic lift();
        hook_off = 1'b1;
        card     = 1'b1;
        repeat (DEBOUNCE + 1) tick();
    endtask

    task automatic hang();
        hook_off = 1'b0;
        repeat (DEBOUNCE + 1) tick();
    endtask

    task automatic dial_local();
        press(4'd5);
        for (int i = 1; i < LOCAL_DIGITS; i++) press(4'($urandom_range(0, 9)));
    endtask

    initial begin
        model_reset();

        // Reset held while inputs toggle: everything stays quiet.
        for (int i = 0; i < 6; i++) begin
            hook_off  = 1'($urandom);
            card      = 1'($urandom);
            key_valid = 1'($urandom);
            key_code  = 4'($urandom);
            answer    = 1'($urandom);
            cut       = 1'($urandom);
            tick();
            check("rst_outs", {state, decide, dial_cnt, busy_tone, digit_err}, 9'd0);
        end
        hook_off = 0; card = 1; key_valid = 0; answer = 0; cut = 0;
        rst_n = 1'b1;
        tick();
        hook_off = 1'b1;
        tick();
        hook_off = 1'b0;
        repeat (5) tick();
        check("glitch_idle", {state, decide, dial_cnt, busy_tone}, 8'd0);

        // Local call.
        lift();
        press(4'd5); press(4'd1); press(4'd2); press(4'd3);
        press(4'd4); press(4'd5); press(4'd6);
        check("local_cnt", dial_cnt, 7);
        check("local_wait_state", state, 0);
        answer = 1'b1;
        tick();
        answer = 1'b0;
        check("local_talk", state, 1);
        check("local_decide", decide, 2'b01);
        hang();
        check("local_hangup", state, 0);

        // Long-distance call, then forced cut.
        lift();
        press(4'd0);
        for (int i = 1; i < LONG_DIGITS; i++) press(4'($urandom_range(0, 9)));
        check("long_cnt", dial_cnt, 11);
        answer = 1'b1;
        tick();
        answer = 1'b0;
        check("long_decide", decide, 2'b10);
        check("long_talk", state, 1);
        cut = 1'b1;
        tick();
        cut = 1'b0;
        check("cut_state", state, 0);
        check("cut_busy", busy_tone, 1);
        hang();
        check("fail_release", busy_tone, 0);

        // Inter-digit timeout, and a key on the timeout cycle.
        lift();
        press(4'd4); press(4'd4); press(4'd4);
        repeat (DIGIT_TMO - 1) tick();
        check("tmo_not_yet", busy_tone, 0);
        tick();
        check("tmo_busy", busy_tone, 1);
        check("tmo_cnt", dial_cnt, 3);
        hang();
        lift();
        press(4'd4); press(4'd4); press(4'd4);
        repeat (DIGIT_TMO - 1) tick();
        press(4'd7);
        check("tmo_key_busy", busy_tone, 0);
        check("tmo_key_cnt", dial_cnt, 4);
        repeat (DIGIT_TMO) tick();
        check("tmo_after_key", busy_tone, 1);
        hang();

        // Illegal key, then card removal during talk.
        lift();
        press(4'd12);
        check("bad_key_err", digit_err, 1);
        check("bad_key_cnt", dial_cnt, 0);
        tick();
        check("bad_key_pulse", digit_err, 0);
        dial_local();
        answer = 1'b1;
        tick();
        answer = 1'b0;
        check("card_talk", state, 1);
        card = 1'b0;
        tick();
        check("card_drop", state, 0);
        hang();

        // Asynchronous reset mid-call.
        lift();
        dial_local();
        answer = 1'b1;
        tick();
        answer = 1'b0;
        check("arst_talk", state, 1);
        #2 rst_n = 1'b0;
        #1 check("arst_drop", state, 0);
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        lift();
        check("arst_fresh_cnt", dial_cnt, 0);
        press(4'd3);
        check("arst_first_digit", dial_cnt, 1);
        hang();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (!rst_n)                          rst_n = 1'b1;
            else if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
            if ($urandom_range(0, 99) < 3) hook_off = ~hook_off;
            card      = ($urandom_range(0, 99) != 0);
            key_valid = ($urandom_range(0, 99) < 30);
            key_code  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 9));
            answer    = ($urandom_range(0, 99) < 5);
            cut       = ($urandom_range(0, 99) < 3);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
